imem_loader: RTL and testbench

Boot-time programmer for the byte-addressed instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and drives them into the instruction memory's write port at consecutive word addresses. It holds the core in reset until the image is fully written and, optionally, checksum-verified. It sits between the host link (UART/debug bridge) and the instruction memory, as the writer counterpart of the fetch-side read port.

---
 rtl/imem_loader_if.sv | 43 ++++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if -- host byte stream plus instruction-memory write port.
//
// Signals:
//   i_start       begin a new load (host -> loader)
//   i_byte_valid  stream byte valid (host -> loader)
//   i_byte        stream byte (host -> loader)
//   o_byte_ready  loader accepts i_byte this cycle
//   o_we          imem write enable, one-cycle pulse per word
//   o_wadr        word-aligned byte address of the write
//   o_wdata       little-endian word to write
//   o_busy        load in progress
//   o_done        last load completed successfully (sticky)
//   o_err         last load failed (sticky)
//   o_core_rst    hold-core-in-reset request
//
// Modports: slave = loader side, master = host/observer side.
interface imem_loader_if #(
  parameter int ADDR_W = 20
);
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_wadr;
  logic [31:0]       o_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_core_rst;

  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_we, o_wadr, o_wdata,
    output o_busy, o_done, o_err, o_core_rst
  );

  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_we, o_wadr, o_wdata,
    input  o_busy, o_done, o_err, o_core_rst
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- boot-time programmer for the instruction memory.
//
// Receives a byte stream: 4-byte little-endian word count N, then 4*N
// payload bytes (little-endian words), optionally one trailing XOR
// checksum byte. Each assembled word is written at consecutive word
// addresses starting at BASE_ADDR. The core is held in reset until the
// load completes successfully.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHK state and the
// payload XOR accumulator; trailing byte must match or the load fails).
//
// Parameters:
//   ADDR_W     byte-address width of instruction memory
//   BASE_ADDR  byte address of the first word (multiple of 4)
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    imem_loader_if.slave (stream handshake, write port, status)
module imem_loader #(
  parameter int          ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  imem_loader_if.slave   bus
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [63:0] MAX_WORDS =
    ((64'd1 << ADDR_W) - 64'(BASE_ADDR)) / 64'd4;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       len_q, len_d;   // first three header bytes
  logic [31:0]       rem_q, rem_d;   // words still to write
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       buf_q, buf_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic              rdy;
  logic              accept;
  logic [31:0]       n_full;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      adr_q   <= BASE;
      buf_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      adr_q   <= adr_d;
      buf_q   <= buf_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    buf_d   = buf_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    accept  = bus.i_byte_valid && rdy;
    // Header byte 3 arrives as the top byte of N.
    n_full  = {bus.i_byte, len_q};

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.i_start) begin
          state_d = LEN;
          idx_d   = '0;
          adr_d   = BASE;
          buf_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          len_d = n_full[31:8];
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rem_d = n_full;
            if ({32'd0, n_full} > MAX_WORDS) begin
              state_d = ERR;
            end else if (n_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          buf_d[{idx_q, 3'b000} +: 8] = bus.i_byte;
`ifdef LOADER_CHECKSUM_EN
          acc_d = acc_q ^ bus.i_byte;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        adr_d = adr_q + ADDR_W'(4);
        rem_d = rem_q - 32'd1;
        if (rem_q == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (bus.i_byte == acc_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs: decoded from the state register only
  always_comb begin
    rdy = (state_q == LEN) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
          || (state_q == CHK)
`endif
          ;
    bus.o_byte_ready = rdy;
    bus.o_we         = (state_q == WRITE);
    bus.o_wadr       = adr_q;
    bus.o_wdata      = buf_q;
    bus.o_busy       = rdy || (state_q == WRITE);
    bus.o_done       = (state_q == DONE);
    bus.o_err        = (state_q == ERR);
    bus.o_core_rst   = (state_q != DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int          AW = 20;
  localparam int unsigned B0 = 32'h0;
  localparam int unsigned B1 = 32'h100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bvalid = 1'b0;
  logic [7:0] bbyte = 8'h00;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) if0 ();
  imem_loader_if #(.ADDR_W(AW)) if1 ();

  assign if0.i_start = start;
  assign if0.i_byte_valid = bvalid;
  assign if0.i_byte = bbyte;
  assign if1.i_start = start;
  assign if1.i_byte_valid = bvalid;
  assign if1.i_byte = bbyte;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(B0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(if0)
  );
  imem_loader #(.ADDR_W(AW), .BASE_ADDR(B1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(if1)
  );

  int total = 0;
  int bad = 0;
  logic [AW+31:0] q0[$];
  logic [AW+31:0] q1[$];
  logic [AW+31:0] e0, e1;
  int unsigned woff;
  logic [7:0] acc;

  // Scoreboard: every write pulse must match the next expected word.
  always @(negedge clk) begin
    if (!rst && if0.o_we) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL we0_unexpected got adr=%h data=%h required no write", if0.o_wadr, if0.o_wdata);
      end else begin
        e0 = q0.pop_front();
        if ({if0.o_wadr, if0.o_wdata} !== e0) begin
          bad++;
          $display("FAIL we0_word got %h_%h required %h_%h", if0.o_wadr, if0.o_wdata, e0[AW+31:32], e0[31:0]);
        end
      end
      total++;
      if (if0.o_byte_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready0_in_write got %b required 0", if0.o_byte_ready);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.o_we) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL we1_unexpected got adr=%h data=%h required no write", if1.o_wadr, if1.o_wdata);
      end else begin
        e1 = q1.pop_front();
        if ({if1.o_wadr, if1.o_wdata} !== e1) begin
          bad++;
          $display("FAIL we1_word got %h_%h required %h_%h", if1.o_wadr, if1.o_wdata, e1[AW+31:32], e1[31:0]);
        end
      end
      total++;
      if (if1.o_byte_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready1_in_write got %b required 0", if1.o_byte_ready);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (all entered at a negedge) ----------
  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    woff = 0;
    acc = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int cyc;
    cyc = 0;
    bbyte = b;
    bvalid = 1'b1;
    while (!if0.o_byte_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout got ready=0 required ready=1 within 50 cycles");
    end else begin
      @(negedge clk);
    end
    bvalid = 1'b0;
    bbyte = $urandom_range(0, 255);
    if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
  endtask

  task automatic send_header(input logic [31:0] n, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], maxgap);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    q0.push_back({AW'(B0 + 4 * woff), w});
    q1.push_back({AW'(B1 + 4 * woff), w});
    woff++;
    for (int k = 0; k < 4; k++) begin
      acc = acc ^ w[8*k +: 8];
      send_byte(w[8*k +: 8], maxgap);
    end
  endtask

  task automatic wait_end();
    int cyc;
    cyc = 0;
    while (!(if0.o_done || if0.o_err) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      total++;
      bad++;
      $display("FAIL end_timeout got done=0 err=0 required done or err");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({if0.o_byte_ready, if0.o_we, if0.o_busy, if0.o_done, if0.o_err, if0.o_core_rst} !== 6'b000001) begin
      bad++;
      $display("FAIL reset0_flags got %b required 000001", {if0.o_byte_ready, if0.o_we, if0.o_busy, if0.o_done, if0.o_err, if0.o_core_rst});
    end
    total++;
    if ({if0.o_wadr, if0.o_wdata} !== {AW'(B0), 32'h0}) begin
      bad++;
      $display("FAIL reset0_bus got %h_%h required %h_0", if0.o_wadr, if0.o_wdata, AW'(B0));
    end
    total++;
    if ({if1.o_wadr, if1.o_wdata, if1.o_core_rst, if1.o_busy} !== {AW'(B1), 32'h0, 2'b10}) begin
      bad++;
      $display("FAIL reset1_bus got %h_%h_%b%b required %h_0_10", if1.o_wadr, if1.o_wdata, if1.o_core_rst, if1.o_busy, AW'(B1));
    end
    rst = 1'b0;
  endtask

  task automatic test_load(input string name, input int maxgap);
    start_load();
    total++;
    if (if0.o_busy !== 1'b1 || if0.o_core_rst !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy got busy=%b core_rst=%b required 1 1", name, if0.o_busy, if0.o_core_rst);
    end
    send_header(32'd2, maxgap);
    send_word(32'h00100093, maxgap);
    send_word(32'h00200113, maxgap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(acc, maxgap);
`endif
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, if0.o_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL %s_end0 got %b required 1000", name, {if0.o_done, if0.o_err, if0.o_core_rst, if0.o_busy});
    end
    total++;
    if ({if1.o_done, if1.o_err, if1.o_core_rst, if1.o_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL %s_end1 got %b required 1000", name, {if1.o_done, if1.o_err, if1.o_core_rst, if1.o_busy});
    end
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got %0d pending required 0", name, q0.size() + q1.size());
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic test_zero();
    start_load();
    send_header(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, if1.o_done} !== 4'b1001) begin
      bad++;
      $display("FAIL zero_end got %b required 1001", {if0.o_done, if0.o_err, if0.o_core_rst, if1.o_done});
    end
  endtask

  task automatic test_overflow();
    start_load();
    send_header(32'h00040001, 0);
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, if0.o_busy} !== 4'b0110) begin
      bad++;
      $display("FAIL ovf_err0 got %b required 0110", {if0.o_done, if0.o_err, if0.o_core_rst, if0.o_busy});
    end
    total++;
    if ({if1.o_err, if1.o_core_rst} !== 2'b11) begin
      bad++;
      $display("FAIL ovf_err1 got %b required 11", {if1.o_err, if1.o_core_rst});
    end
    start_load();
    total++;
    if (if0.o_err !== 1'b0) begin
      bad++;
      $display("FAIL ovf_err_clear got %b required 0", if0.o_err);
    end
    send_header(32'd1, 1);
    send_word(32'hDEADBEEF, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(acc, 0);
`endif
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0} !== 4'b1001) begin
      bad++;
      $display("FAIL ovf_reload got %b required 1001", {if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0});
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_load();
    send_header(32'd1, 0);
    send_word(32'h00000013, 0);
    send_byte(8'h12, 0);
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0} !== 4'b0111) begin
      bad++;
      $display("FAIL chk_bad got %b required 0111", {if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0});
    end
    start_load();
    send_header(32'd1, 0);
    send_word(32'h00000013, 0);
    send_byte(8'h13, 0);
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0} !== 4'b1001) begin
      bad++;
      $display("FAIL chk_good got %b required 1001", {if0.o_done, if0.o_err, if0.o_core_rst, q0.size() == 0});
    end
  endtask
`endif

  task automatic test_start_ignored();
    start_load();
    send_header(32'd1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'hA5C30F81, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(acc, 0);
`endif
    wait_end();
    total++;
    if ({if0.o_done, if0.o_err, q0.size() == 0, q1.size() == 0} !== 4'b1011) begin
      bad++;
      $display("FAIL start_ignored got %b required 1011", {if0.o_done, if0.o_err, q0.size() == 0, q1.size() == 0});
    end
  endtask

  task automatic test_reset_mid();
    start_load();
    send_header(32'd2, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({if0.o_byte_ready, if0.o_we, if0.o_busy, if0.o_done, if0.o_err, if0.o_core_rst} !== 6'b000001) begin
      bad++;
      $display("FAIL rstmid_flags got %b required 000001", {if0.o_byte_ready, if0.o_we, if0.o_busy, if0.o_done, if0.o_err, if0.o_core_rst});
    end
    total++;
    if ({if0.o_wadr, if0.o_wdata, if1.o_wadr} !== {AW'(B0), 32'h0, AW'(B1)}) begin
      bad++;
      $display("FAIL rstmid_bus got %h_%h_%h required %h_0_%h", if0.o_wadr, if0.o_wdata, if1.o_wadr, AW'(B0), AW'(B1));
    end
    @(negedge clk);
    rst = 1'b0;
    test_load("rstmid_reload", 0);
  endtask

  initial begin
    test_reset();
    test_load("basic", 0);
    test_load("gaps", 3);
    test_zero();
    test_overflow();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_start_ignored();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
